// File: rtl/id_ex_stage.sv
// id_ex_stage: decodes the RV32I ALU subset (OP, OP-IMM, LUI, AUIPC) into operands and an ALU opcode held in one pipeline slot.
// Latency: one cycle from an accepted input to out_valid. Throughput is one instruction per cycle while out_ready is high.
// Backpressure: in_ready = !out_valid || out_ready. The slot holds steady while out_valid && !out_ready. Define FORWARD_EN to enable execute-stage operand forwarding.
module id_ex_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] pc,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic            fwd_we,
   input  logic [4:0]      fwd_rd,
   input  logic [XLEN-1:0] fwd_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] operand_a,
   output logic [XLEN-1:0] operand_b,
   output logic [3:0]      alu_op,
   output logic [4:0]      rd,
   output logic            rd_we,
   output logic            illegal
);

   // ALU opcode map: [3:2] selects the class, [1:0] the operation within it
   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_SLT  = 4'b0010;
   localparam logic [3:0] OP_SLTU = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0100;
   localparam logic [3:0] OP_OR   = 4'b0101;
   localparam logic [3:0] OP_XOR  = 4'b0110;
   localparam logic [3:0] OP_SLL  = 4'b1000;
   localparam logic [3:0] OP_SRL  = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1010;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // instruction fields
   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;
   logic [4:0] rs1_idx;
   logic [4:0] rs2_idx;
   logic [4:0] rd_idx;

   assign opcode  = instr[6:0];
   assign f3      = instr[14:12];
   assign f7      = instr[31:25];
   assign rs1_idx = instr[19:15];
   assign rs2_idx = instr[24:20];
   assign rd_idx  = instr[11:7];

   // register operand sources, optionally bypassed from the execute stage
   logic [XLEN-1:0] src1;
   logic [XLEN-1:0] src2;

`ifdef FORWARD_EN
   // x0 is never forwarded: a write to x0 carries no architectural value
   always_comb begin
      src1 = rs1_data;
      src2 = rs2_data;
      if (fwd_we && (fwd_rd != 5'd0) && (fwd_rd == rs1_idx)) begin
         src1 = fwd_data;
      end
      if (fwd_we && (fwd_rd != 5'd0) && (fwd_rd == rs2_idx)) begin
         src2 = fwd_data;
      end
   end
`else
   // forwarding ports exist for a uniform interface but carry no meaning here
   logic unused_fwd;
   assign unused_fwd = ^{fwd_we, fwd_rd, fwd_data};
   assign src1 = rs1_data;
   assign src2 = rs2_data;
`endif

   // immediates
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] imm_sh;

   assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
   assign imm_u  = {instr[31:12], 12'b0};
   assign imm_sh = {{(XLEN-5){1'b0}}, instr[24:20]};

   // combinational decode of the presented instruction
   logic [XLEN-1:0] dec_a;
   logic [XLEN-1:0] dec_b;
   logic [3:0]      dec_op;
   logic            dec_illegal;

   // decode operands/opcode; anything unsupported collapses to a zero-operand ADD flagged illegal
   always_comb begin
      dec_a       = '0;
      dec_b       = '0;
      dec_op      = OP_ADD;
      dec_illegal = 1'b0;
      unique case (opcode)
         OPC_OP: begin
            dec_a = src1;
            dec_b = src2;
            unique case (f3)
               3'b000: dec_op = (f7 == F7_ALT) ? OP_SUB : OP_ADD;
               3'b001: dec_op = OP_SLL;
               3'b010: dec_op = OP_SLT;
               3'b011: dec_op = OP_SLTU;
               3'b100: dec_op = OP_XOR;
               3'b101: dec_op = (f7 == F7_ALT) ? OP_SRA : OP_SRL;
               3'b110: dec_op = OP_OR;
               default: dec_op = OP_AND;
            endcase
            // the alternate funct7 only selects SUB or SRA
            if (!((f7 == F7_ZERO) ||
                  ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))))) begin
               dec_illegal = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            dec_a = src1;
            dec_b = imm_i;
            unique case (f3)
               3'b000: dec_op = OP_ADD;
               3'b001: begin
                  dec_op = OP_SLL;
                  dec_b  = imm_sh;
                  if (f7 != F7_ZERO) begin
                     dec_illegal = 1'b1;
                  end
               end
               3'b010: dec_op = OP_SLT;
               3'b011: dec_op = OP_SLTU;
               3'b100: dec_op = OP_XOR;
               3'b101: begin
                  dec_op = (f7 == F7_ALT) ? OP_SRA : OP_SRL;
                  dec_b  = imm_sh;
                  if ((f7 != F7_ZERO) && (f7 != F7_ALT)) begin
                     dec_illegal = 1'b1;
                  end
               end
               3'b110: dec_op = OP_OR;
               default: dec_op = OP_AND;
            endcase
         end
         OPC_LUI: begin
            dec_a  = '0;
            dec_b  = imm_u;
            dec_op = OP_ADD;
         end
         OPC_AUIPC: begin
            dec_a  = pc;
            dec_b  = imm_u;
            dec_op = OP_ADD;
         end
         default: begin
            dec_illegal = 1'b1;
         end
      endcase
      // illegal slots still travel downstream, but with neutral operands
      if (dec_illegal) begin
         dec_a  = '0;
         dec_b  = '0;
         dec_op = OP_ADD;
      end
   end

   // pipeline slot state
   logic            out_valid_q, out_valid_d;
   logic [XLEN-1:0] operand_a_q, operand_a_d;
   logic [XLEN-1:0] operand_b_q, operand_b_d;
   logic [3:0]      alu_op_q, alu_op_d;
   logic [4:0]      rd_q, rd_d;
   logic            rd_we_q, rd_we_d;
   logic            illegal_q, illegal_d;

   logic load;

   assign in_ready = !out_valid_q || out_ready;
   assign load     = in_valid && in_ready && !flush;

   // next slot contents: flush beats load, load beats drain, otherwise hold
   always_comb begin
      out_valid_d = out_valid_q;
      operand_a_d = operand_a_q;
      operand_b_d = operand_b_q;
      alu_op_d    = alu_op_q;
      rd_d        = rd_q;
      rd_we_d     = rd_we_q;
      illegal_d   = illegal_q;
      if (flush) begin
         out_valid_d = 1'b0;
      end else if (load) begin
         out_valid_d = 1'b1;
         operand_a_d = dec_a;
         operand_b_d = dec_b;
         alu_op_d    = dec_op;
         rd_d        = rd_idx;
         rd_we_d     = !dec_illegal && (rd_idx != 5'd0);
         illegal_d   = dec_illegal;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // slot registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         operand_a_q <= '0;
         operand_b_q <= '0;
         alu_op_q    <= '0;
         rd_q        <= '0;
         rd_we_q     <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         operand_a_q <= operand_a_d;
         operand_b_q <= operand_b_d;
         alu_op_q    <= alu_op_d;
         rd_q        <= rd_d;
         rd_we_q     <= rd_we_d;
         illegal_q   <= illegal_d;
      end
   end

   assign out_valid = out_valid_q;
   assign operand_a = operand_a_q;
   assign operand_b = operand_b_q;
   assign alu_op    = alu_op_q;
   assign rd        = rd_q;
   assign rd_we     = rd_we_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed test of the id_ex_stage decode/issue slot.
// Inputs change 1ns after a rising edge; outputs are sampled 1ns after the next one.
// Expected values are hand-derived from the instruction encodings.
module tb_id_ex_stage;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] pc;
   logic [31:0] instr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        fwd_we;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic [3:0]  alu_op;
   logic [4:0]  rd;
   logic        rd_we;
   logic        illegal;

   int n_assert = 0;
   int n_fail   = 0;

   id_ex_stage #(.XLEN(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .pc        (pc),
      .instr     (instr),
      .rs1_data  (rs1_data),
      .rs2_data  (rs2_data),
      .fwd_we    (fwd_we),
      .fwd_rd    (fwd_rd),
      .fwd_data  (fwd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .alu_op    (alu_op),
      .rd        (rd),
      .rd_we     (rd_we),
      .illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; pc = '0; instr = '0;
      rs1_data = '0; rs2_data = '0; fwd_we = 1'b0; fwd_rd = '0; fwd_data = '0;
      out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();

      // reset / idle
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_a", operand_a, 32'd0);
      chk("rst_b", operand_b, 32'd0);
      chk("rst_alu_op", {28'b0, alu_op}, 32'd0);
      chk("rst_rd", {27'b0, rd}, 32'd0);
      chk("rst_rd_we", {31'b0, rd_we}, 32'd0);
      chk("rst_illegal", {31'b0, illegal}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

      // sub x2,x1,x2
      instr = 32'h40208133; rs1_data = 32'd10; rs2_data = 32'd3; in_valid = 1'b1;
      tick();
      chk("sub_valid", {31'b0, out_valid}, 32'd1);
      chk("sub_a", operand_a, 32'd10);
      chk("sub_b", operand_b, 32'd3);
      chk("sub_op", {28'b0, alu_op}, 32'h1);
      chk("sub_rd", {27'b0, rd}, 32'd2);
      chk("sub_rd_we", {31'b0, rd_we}, 32'd1);
      chk("sub_illegal", {31'b0, illegal}, 32'd0);

      // slti x1,x1,-1 then srai x1,x1,5 back to back
      instr = 32'hFFF0A093; rs1_data = 32'd5;
      tick();
      chk("slti_a", operand_a, 32'd5);
      chk("slti_b", operand_b, 32'hFFFFFFFF);
      chk("slti_op", {28'b0, alu_op}, 32'h2);
      instr = 32'h4050D093;
      tick();
      chk("srai_valid", {31'b0, out_valid}, 32'd1);
      chk("srai_b", operand_b, 32'd5);
      chk("srai_op", {28'b0, alu_op}, 32'hA);

      // drain
      in_valid = 1'b0;
      tick();
      chk("drain_valid", {31'b0, out_valid}, 32'd0);

      // auipc x10,1 held under backpressure
      pc = 32'h100; instr = 32'h00001517; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      // next instruction waits at the input: add x3,x1,x1
      instr = 32'h001081B3; rs1_data = 32'd9; rs2_data = 32'd9; pc = 32'h104;
      for (int i = 0; i < 3; i++) begin
         chk("stall_valid", {31'b0, out_valid}, 32'd1);
         chk("stall_a", operand_a, 32'h100);
         chk("stall_b", operand_b, 32'h1000);
         chk("stall_op", {28'b0, alu_op}, 32'h0);
         chk("stall_rd", {27'b0, rd}, 32'd10);
         chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
         tick();
      end
      chk("stall_end_a", operand_a, 32'h100);
      out_ready = 1'b1;
      #1;
      chk("release_in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      chk("next_valid", {31'b0, out_valid}, 32'd1);
      chk("next_a", operand_a, 32'd9);
      chk("next_rd", {27'b0, rd}, 32'd3);

      // flush with in_valid while the slot is full: input dropped
      out_ready = 1'b0; flush = 1'b1; instr = 32'h0000000B;
      tick();
      chk("flush_valid", {31'b0, out_valid}, 32'd0);
      chk("flush_hold_a", operand_a, 32'd9);
      chk("flush_in_ready", {31'b0, in_ready}, 32'd1);

      // custom-0 opcode is illegal but still issued
      flush = 1'b0; out_ready = 1'b1;
      tick();
      chk("ill_valid", {31'b0, out_valid}, 32'd1);
      chk("ill_illegal", {31'b0, illegal}, 32'd1);
      chk("ill_rd_we", {31'b0, rd_we}, 32'd0);
      chk("ill_a", operand_a, 32'd0);
      chk("ill_b", operand_b, 32'd0);
      chk("ill_op", {28'b0, alu_op}, 32'h0);

      // AND with funct7=0100000 is illegal
      instr = 32'h4020F133;
      tick();
      chk("and_f7_illegal", {31'b0, illegal}, 32'd1);
      chk("and_f7_rd_we", {31'b0, rd_we}, 32'd0);

      // SLLI with funct7=0100000 is illegal
      instr = 32'h40109093;
      tick();
      chk("slli_f7_illegal", {31'b0, illegal}, 32'd1);

      // add x0,x1,x2: legal but no writeback
      instr = 32'h00208033; rs1_data = 32'd4; rs2_data = 32'd6;
      tick();
      chk("x0_illegal", {31'b0, illegal}, 32'd0);
      chk("x0_rd_we", {31'b0, rd_we}, 32'd0);
      chk("x0_b", operand_b, 32'd6);

      // lui x5,0x12345: operand A forced to zero
      instr = 32'h123452B7; rs1_data = 32'h0000DEAD;
      tick();
      chk("lui_a", operand_a, 32'd0);
      chk("lui_b", operand_b, 32'h12345000);
      chk("lui_rd_we", {31'b0, rd_we}, 32'd1);

      // forwarding: add x3,x1,x1 with an execute-stage write to x1
      instr = 32'h001081B3; rs1_data = 32'd1; rs2_data = 32'd1;
      fwd_we = 1'b1; fwd_rd = 5'd1; fwd_data = 32'd7;
      tick();
`ifdef FORWARD_EN
      chk("fwd_a", operand_a, 32'd7);
      chk("fwd_b", operand_b, 32'd7);
`else
      chk("nofwd_a", operand_a, 32'd1);
      chk("nofwd_b", operand_b, 32'd1);
`endif
      fwd_rd = 5'd0;
      tick();
      chk("fwd_x0_a", operand_a, 32'd1);
      chk("fwd_x0_b", operand_b, 32'd1);
      fwd_we = 1'b0;

      // reset during a stall empties the slot
      instr = 32'h40208133; rs1_data = 32'd10; rs2_data = 32'd3; out_ready = 1'b0;
      tick();
      chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
      rst = 1'b1;
      tick();
      chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
      chk("mid_rst_a", operand_a, 32'd0);
      chk("mid_rst_op", {28'b0, alu_op}, 32'd0);
      rst = 1'b0; in_valid = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode/issue pipeline stage that sits directly upstream of the ALU.
- Accepts a fetched RV32I instruction plus its register-file read data, decodes the ALU subset (OP, OP-IMM, LUI, AUIPC), and selects the ALU operands.
- Produces the 4-bit ALU opcode and registers everything into one pipeline slot with a valid/ready handshake, so the ALU sees stable operands for the whole execute cycle.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard the held slot and the current input.
- in_valid  in  1  instr/pc/rs*_data are valid.
- in_ready  out  1  stage can accept the input this cycle.
- pc  in  32  PC of the instruction.
- instr  in  32  raw instruction word.
- rs1_data  in  32  register-file read of instr[19:15].
- rs2_data  in  32  register-file read of instr[24:20].
- fwd_we  in  1  execute-stage result will be written back (FORWARD_EN only).
- fwd_rd  in  5  destination of the execute-stage result (FORWARD_EN only).
- fwd_data  in  32  execute-stage ALU result (FORWARD_EN only).
- out_valid  out  1  registered slot holds an instruction.
- out_ready  in  1  ALU/execute stage consumes the slot.
- operand_a  out  32  registered ALU operand A.
- operand_b  out  32  registered ALU operand B.
- alu_op  out  4  registered ALU opcode.
- rd  out  5  destination register.
- rd_we  out  1  writeback enable.
- illegal  out  1  instruction outside the supported subset.

Behaviour:
- ALU opcode encoding is fixed:
  - alu_op[3:2]: 00 arithmetic, 01 logical, 10 shift.
  - Arithmetic, alu_op[1:0]: 00 ADD, 01 SUB, 10 SLT, 11 SLTU.
  - Logical, alu_op[1:0]: 00 AND, 01 OR, 10 XOR.
  - Shift, alu_op[1:0]: 00 SLL, 01 SRL, 10 SRA.
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational and holds during flush as well.
  - Load occurs when in_valid && in_ready && !flush.
- Slot update, in priority order:
  - rst: out_valid=0, operand_a=0, operand_b=0, alu_op=0, rd=0, rd_we=0, illegal=0.
  - flush: out_valid=0 next cycle; other outputs don't-care but hold. The input is dropped even if in_valid=1.
  - load: capture decode results; out_valid=1.
  - out_ready && !load: out_valid=0.
  - otherwise: hold all outputs unchanged (stall). Outputs must not change while out_valid && !out_ready.
- Latency: 1 cycle from accepted input to out_valid. Back-to-back throughput is 1 per cycle while out_ready=1.
- Decode, by opcode = instr[6:0], f3 = instr[14:12], f7 = instr[31:25]:
  - OP (0110011): a=rs1, b=rs2.
    - f3 000: ADD, or SUB if f7=0100000.
    - f3 001: SLL. f3 010: SLT. f3 011: SLTU. f3 100: XOR.
    - f3 101: SRL, or SRA if f7=0100000.
    - f3 110: OR. f3 111: AND.
    - f7 must be 0000000; 0100000 is legal only with f3 000 or 101.
  - OP-IMM (0010011): a=rs1, b=sign-extended instr[31:20], same f3 map with f3 000 always ADD.
    - For shifts, b={27'b0, instr[24:20]}.
    - SLLI requires f7=0000000; SRLI/SRAI require f7 of 0000000 or 0100000.
  - LUI (0110111): a=0, b={instr[31:12],12'b0}, ADD.
  - AUIPC (0010111): a=pc, b={instr[31:12],12'b0}, ADD.
  - Any other opcode or illegal f7: illegal=1, rd_we=0, a=0, b=0, alu_op=ADD, out_valid=1. The slot still flows downstream for trap handling.
- rd = instr[11:7]. rd_we = !illegal && rd!=0.
- Reset during a stall or mid-stream: the slot empties on the next edge and no output is retained.

Optional Feature:
- Macro: FORWARD_EN.
- Defined: at load time, rs1_data is replaced by fwd_data when fwd_we && fwd_rd!=0 && fwd_rd==instr[19:15]. The same rule applies to rs2_data with instr[24:20]. The substitution is used only where the value is an operand source; pc, 0 and immediates are unaffected.
- Undefined: the fwd_* ports still exist but are ignored; rs1_data/rs2_data are used directly.

Test Plan:
- Reset, then idle -> out_valid=0, all outputs 0, in_ready=1.
- instr=0x40208133 (sub x2,x1,x2), rs1_data=10, rs2_data=3 -> one cycle later: out_valid=1, a=10, b=3, alu_op=0001, rd=2, rd_we=1, illegal=0.
- instr=0xFFF0A093 (slti x1,x1,-1), then 0x4050D093 (srai x1,x1,5) -> first: b=0xFFFFFFFF, alu_op=0010; second: b=5, alu_op=1010.
- AUIPC with pc=0x100, instr=0x00001517 (auipc x10,1) held under out_ready=0 for 3 cycles -> a=0x100, b=0x1000, alu_op=0000 stable; in_ready=0 throughout; next instruction is accepted only after out_ready=1.
- flush asserted together with in_valid=1 while the slot is full -> out_valid=0 next cycle, input dropped; instr=0x0000000B -> illegal=1, rd_we=0.
- FORWARD_EN: add x3,x1,x1 with rs1_data=1, fwd_we=1, fwd_rd=1, fwd_data=7 -> a=7, b=7; with fwd_rd=0 -> a=1, b=1.
